// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit after data).
package uart_pack;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or after ptr, with wrap.
// The pointer register itself lives in the parent.
module rr_arbiter
  import uart_pack::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  localparam logic [IW:0]         NR  = (IW+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0]  ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IW:0] cand;

  // Walk candidates ptr, ptr+1, ... (mod NUM_REQ); the first pending one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= NR) cand = cand - NR;
      if (!valid && (|((req >> cand) & ONE))) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

  // One-hot decode of the winning index.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = valid && (idx == IW'(i));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx line among NUM_REQ byte producers with round-robin
// arbitration. Frame: start(0), DATA_WIDTH bits LSB-first, [parity], stop(1).
// Optional feature macro: UART_PARITY_EN (even parity bit between data and stop).
// tx/busy are registered one cycle behind the FSM state, so a grant visible in
// cycle T puts the start bit on tx from T+1.
module uart_tx_arbiter
  import uart_pack::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int IW  = idx_w(NUM_REQ);
  localparam int BW  = idx_w(CLKS_PER_BIT);
  localparam int BIW = idx_w(DATA_WIDTH);

  localparam logic [IW-1:0]  PTR_LAST  = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] BIT_LAST  = BIW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [IW-1:0]         ptr;
  logic [BW-1:0]         baud;
  logic [BIW-1:0]        bidx;
  logic [DATA_WIDTH-1:0] sh;
`ifdef UART_PARITY_EN
  logic                  par;
`endif

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] dsel;
  logic                  baud_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Byte of the winning requester, captured only on the grant edge.
  always_comb begin
    dsel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_idx == IW'(i)) dsel = data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign baud_last = (baud == BAUD_LAST);

  // Frame FSM with baud counter, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      tx    <= 1'b1;
      baud  <= '0;
      bidx  <= '0;
      sh    <= '0;
`ifdef UART_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      gnt  <= '0;
      busy <= (state != IDLE);
      if (state != IDLE) baud <= baud_last ? '0 : baud + 1'b1;
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          bidx <= '0;
          if (arb_valid) begin
            gnt   <= arb_gnt;
            owner <= arb_idx;
            ptr   <= (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
            sh    <= dsel;
`ifdef UART_PARITY_EN
            par   <= ^dsel;
`endif
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_last) state <= DATA;
        end
        DATA: begin
          tx <= sh[0];
          if (baud_last) begin
            sh <= sh >> 1;
            if (bidx == BIT_LAST) begin
              bidx  <= '0;
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          tx <= par;
          if (baud_last) state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a cycle-level arbitration model pushes
// expected grants (requester, byte, cycle); a negedge monitor pops them on each
// gnt pulse and decodes the serial frame from tx mid-bit samples.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int PERIOD = NB*CPB + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N*DW-1:0]      data = '0;
  logic [N-1:0]         gnt;
  logic                 tx;
  logic                 busy;
  logic [$clog2(N)-1:0] owner;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .tx    (tx),
    .busy  (busy),
    .owner (owner)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          idx;
    logic [DW-1:0] byte_;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  // Reference model: whenever the line has been free for a full frame period,
  // the first pending requester at or after the pointer is granted.
  int m_ptr = 0;
  int m_next_ok = 0;
  always @(posedge clk) begin
    exp_t e;
    logic [N-1:0] r;
    cyc++;
    r = req;
    if (!rst_n) begin
      m_ptr = 0;
      m_next_ok = 0;
      q.delete();
    end else if (cyc >= m_next_ok && r != 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (r[k]) begin
          e.idx = k;
          e.byte_ = data[k*DW +: DW];
          e.cyc = cyc;
          q.push_back(e);
          m_ptr = (k + 1) % N;
          m_next_ok = cyc + PERIOD;
          break;
        end
      end
    end
  end

  // Monitor: pops an expectation at every gnt pulse and checks the frame.
  exp_t        cur;
  int          tg = 0;
  bit          act = 1'b0;
  int          last_g = -1000000;
  logic [NB-1:0] bits;
  always @(negedge clk) begin
    logic [NB-1:0] eb;
    int off;
    if (!rst_n) begin
      act = 1'b0;
      last_g = -1000000;
    end else begin
      if (act) begin
        off = cyc - tg - 1;
        if (off == 0) begin
          chk("start_first_cycle_tx", tx, 0);
          chk("owner", owner, cur.idx);
          chk("busy_after_gnt", busy, 1);
        end
        if (off >= 0 && off < NB*CPB && (off % CPB) == CPB/2) bits[off/CPB] = tx;
        if (off == NB*CPB - 1) begin
          eb = '0;
          eb[0] = 1'b0;
          for (int i = 0; i < DW; i++) eb[1+i] = cur.byte_[i];
`ifdef UART_PARITY_EN
          eb[DW+1] = ^cur.byte_;
`endif
          eb[NB-1] = 1'b1;
          chk("frame_bits", bits, eb);
          chk("last_stop_tx", tx, 1);
          chk("busy_last_stop", busy, 1);
        end
        if (off == NB*CPB) begin
          chk("idle_gap_tx", tx, 1);
          chk("busy_cleared", busy, 0);
          act = 1'b0;
        end
      end
      if (gnt != 0) begin
        chk("gnt_onehot", $onehot(gnt), 1);
        chk("gnt_while_busy", busy, 0);
        chk("gnt_spacing", (cyc - last_g) >= PERIOD, 1);
        last_g = cyc;
        if (q.size() == 0) begin
          chk("unexpected_gnt", gnt, 0);
        end else begin
          cur = q.pop_front();
          chk("gnt_index", gnt, 32'(1) << cur.idx);
          chk("gnt_cycle", cyc, cur.cyc);
          tg = cyc;
          act = 1'b1;
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missing_gnt", gnt, 32'(1) << q[0].idx);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_gnt(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (gnt != 0) return;
    end
    chk("gnt_timeout", gnt, 32'hFFFF_FFFF);
  endtask

  task automatic settle();
    repeat (PERIOD + 4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    rst_n = 1'b1;

    // Single requester, 0x55
    data[7:0] = 8'h55;
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    data[7:0] = 8'hFF;  // must not affect the frame in flight
    settle();

    // All requesters held: five back-to-back grants
    data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_gnt(PERIOD + 10);
    req = 4'b0000;
    settle();

    // Pointer after granting 1, then req=1001 -> 3 then 0
    req = 4'b0010;
    wait_gnt(20);
    req = 4'b1001;
    wait_gnt(PERIOD + 10);
    wait_gnt(PERIOD + 10);
    req = 4'b0000;
    settle();

    // req[2] pulses only while a frame is in flight
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    repeat (20) @(negedge clk);
    req = 4'b0100;
    repeat (60) @(negedge clk);
    req = 4'b0000;
    settle();

    // Reset in the middle of the 4th data bit of a frame from requester 2
    data[23:16] = 8'hA5;
    req = 4'b0100;
    wait_gnt(20);
    req = 4'b0000;
    repeat (1 + 16*4 + 8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_owner", owner, 0);
    chk("async_reset_gnt", gnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    wait_gnt(20);
    chk("post_reset_gnt", gnt, 4'b0010);
    req = 4'b0000;
    settle();

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) req = N'($urandom);
      if ($urandom_range(0, 5) == 0) data[$urandom_range(0, N-1)*DW +: DW] = DW'($urandom);
    end
    req = 4'b0000;
    settle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
